gate_op_sequencer: RTL and testbench

//  Parametrised logic unit for the DE0-CV gate exercises. It applies one of

---
 rtl/gate_op_sequencer.sv | 142 ++++++++++++++
 tb/tb_gate_op_sequencer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/gate_op_sequencer.sv
// gate_op_sequencer: eight-way bitwise logic unit for the DE0-CV gate exercises.
// Operands come from the slide switches, the operation is stepped with debounced
// push-buttons, and the result is registered onto the LEDs (optionally frozen).
module gate_op_sequencer #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [3:0]         key,
    input  logic [2*WIDTH-1:0] sw,
    output logic [WIDTH-1:0]   result,
    output logic [2:0]         op,
    output logic               hold
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    // Operation codes
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd3;
    localparam logic [2:0] OP_NOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOTA = 3'd6;
    localparam logic [2:0] OP_ANDN = 3'd7;

    logic [3:0]         key_meta_reg;
    logic [3:0]         key_sync_reg;
    logic [2*WIDTH-1:0] sw_meta_reg;
    logic [2*WIDTH-1:0] sw_sync_reg;

    logic [3:0]         key_db_reg;   // debounced key level, 1 = released
    logic [3:0]         press;        // 1-cycle pulse on released->pressed

    logic [2:0]         op_reg;
    logic [2:0]         op_next;
    logic               hold_reg;
    logic [WIDTH-1:0]   result_reg;
    logic [WIDTH-1:0]   result_next;

    logic [WIDTH-1:0]   a_sync;
    logic [WIDTH-1:0]   b_sync;

    assign a_sync = sw_sync_reg[WIDTH-1:0];
    assign b_sync = sw_sync_reg[2*WIDTH-1:WIDTH];

    // Two-flop synchronisers for the asynchronous keys and switches; released (all ones) out of reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            key_meta_reg <= '1;
            key_sync_reg <= '1;
            sw_meta_reg  <= '1;
            sw_sync_reg  <= '1;
        end else begin
            key_meta_reg <= key;
            key_sync_reg <= key_meta_reg;
            sw_meta_reg  <= sw;
            sw_sync_reg  <= sw_meta_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_debounce
            logic [CW-1:0] cnt_reg;
            logic          accept;

            // The synced level has differed for DEBOUNCE_CYCLES consecutive edges as of this edge
            assign accept    = (key_sync_reg[gi] != key_db_reg[gi]) && (cnt_reg == CNT_MAX);
            // The pulse is issued on the same edge the debounced state flips to pressed
            assign press[gi] = accept && key_db_reg[gi] && !key_sync_reg[gi];

            // Per-key debounce: count consecutive differing cycles, adopt the new level on the last one
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    cnt_reg         <= '0;
                    key_db_reg[gi]  <= 1'b1;
                end else if (key_sync_reg[gi] == key_db_reg[gi]) begin
                    cnt_reg <= '0;
                end else if (accept) begin
                    cnt_reg         <= '0;
                    key_db_reg[gi]  <= key_sync_reg[gi];
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end
        end
    endgenerate

    // Next op: reset key wins, opposing step keys cancel, otherwise step with 3-bit wrap
    always_comb begin
        op_next = op_reg;
        if (press[3]) begin
            op_next = OP_AND;
        end else if (press[0] && !press[1]) begin
            op_next = op_reg + 3'd1;
        end else if (press[1] && !press[0]) begin
            op_next = op_reg - 3'd1;
        end
    end

    // Bitwise operation table on the synchronised operands
    always_comb begin
        result_next = '0;
        case (op_reg)
            OP_AND:  result_next = a_sync & b_sync;
            OP_OR:   result_next = a_sync | b_sync;
            OP_XOR:  result_next = a_sync ^ b_sync;
            OP_NAND: result_next = ~(a_sync & b_sync);
            OP_NOR:  result_next = ~(a_sync | b_sync);
            OP_XNOR: result_next = ~(a_sync ^ b_sync);
            OP_NOTA: result_next = ~a_sync;
            OP_ANDN: result_next = a_sync & ~b_sync;
            default: result_next = '0;
        endcase
    end

    // Control registers: op, hold toggle, and the result register frozen while hold is set
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            op_reg     <= OP_AND;
            hold_reg   <= 1'b0;
            result_reg <= '0;
        end else begin
            op_reg <= op_next;
            if (press[2]) begin
                hold_reg <= ~hold_reg;
            end
            if (!hold_reg) begin
                result_reg <= result_next;
            end
        end
    end

    assign result = result_reg;
    assign op     = op_reg;
    assign hold   = hold_reg;

endmodule

// File: tb/tb_gate_op_sequencer.sv
// Directed bench for gate_op_sequencer with WIDTH=5 and a 4-cycle debounce.
module tb_gate_op_sequencer;

    localparam int WIDTH = 5;
    localparam int DB    = 4;

    logic               clk;
    logic               reset_n;
    logic [3:0]         key;
    logic [2*WIDTH-1:0] sw;
    logic [WIDTH-1:0]   result;
    logic [2:0]         op;
    logic               hold;

    int err_cnt = 0;
    int chk_cnt = 0;

    gate_op_sequencer #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .key(key),
        .sw(sw),
        .result(result),
        .op(op),
        .hold(hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Press the keys in mask (1 = pressed) long enough to debounce, then release and settle
    task automatic press_key(input logic [3:0] mask);
        key = ~mask;
        tick(2 + DB + 2);
        key = 4'hF;
        tick(2 + DB + 2);
    endtask

    task automatic set_ab(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        sw = {b, a};
    endtask

    localparam logic [WIDTH-1:0] A1 = 5'b10110;
    localparam logic [WIDTH-1:0] B1 = 5'b01100;
    logic [WIDTH-1:0] seq_exp [1:7];

    initial begin
        seq_exp[1] = 5'b11110; seq_exp[2] = 5'b11010; seq_exp[3] = 5'b11011;
        seq_exp[4] = 5'b00001; seq_exp[5] = 5'b00101; seq_exp[6] = 5'b01001;
        seq_exp[7] = 5'b10010;

        // 1. Reset with all keys pressed
        reset_n = 1'b0;
        key     = 4'b0000;
        sw      = '0;
        tick(3);
        check_value("rst_op", 32'(op), 32'd0);
        check_value("rst_result", 32'(result), 32'd0);
        check_value("rst_hold", 32'(hold), 32'd0);

        // Keep key[0] pressed across reset release: exactly one increment
        key = 4'b1110;
        tick(1);
        reset_n = 1'b1;
        tick(2 + DB - 1);
        check_value("rst_key_before", 32'(op), 32'd0);
        tick(1);
        check_value("rst_key_inc", 32'(op), 32'd1);
        tick(12);
        check_value("rst_key_norepeat", 32'(op), 32'd1);
        key = 4'hF;
        tick(10);
        check_value("rst_key_release", 32'(op), 32'd1);
        press_key(4'b1000);
        check_value("clr_op", 32'(op), 32'd0);

        // 2. AND path latency: exactly 3 edges from sw change
        set_ab(A1, B1);
        tick(2);
        check_value("and_edge2", 32'(result), 32'd0);
        tick(1);
        check_value("and_edge3", 32'(result), 32'(5'b00100));

        // 3. Step through ops 1..7
        for (int i = 1; i <= 7; i++) begin
            press_key(4'b0001);
            check_value($sformatf("seq_op%0d", i), 32'(op), 32'(i));
            check_value($sformatf("seq_res%0d", i), 32'(result), 32'(seq_exp[i]));
        end

        // 4. Wrap and simultaneous keys
        press_key(4'b0001);
        check_value("wrap_up", 32'(op), 32'd0);
        press_key(4'b0010);
        check_value("wrap_down", 32'(op), 32'd7);
        press_key(4'b0011);
        check_value("both_step", 32'(op), 32'd7);
        press_key(4'b1001);
        check_value("clr_prio", 32'(op), 32'd0);

        // 5. Glitch rejection
        key = 4'b1110;
        tick(3);
        key = 4'hF;
        tick(12);
        check_value("glitch3", 32'(op), 32'd0);
        key = 4'b1110;
        tick(4);
        key = 4'hF;
        tick(12);
        check_value("press4", 32'(op), 32'd1);
        // bouncy press from released state
        for (int i = 0; i < 4; i++) begin
            key = 4'b1110; tick(1);
            key = 4'hF;    tick(1);
        end
        tick(10);
        check_value("bouncy_press", 32'(op), 32'd1);
        // hold key[0] pressed, then bounce on release
        key = 4'b1110;
        tick(10);
        check_value("held_once", 32'(op), 32'd2);
        for (int i = 0; i < 4; i++) begin
            key = 4'hF;    tick(1);
            key = 4'b1110; tick(1);
        end
        key = 4'hF;
        tick(12);
        check_value("bouncy_release", 32'(op), 32'd2);
        press_key(4'b0010);
        check_value("back_op1", 32'(op), 32'd1);
        check_value("back_res1", 32'(result), 32'(5'b11110));

        // 6. Hold
        press_key(4'b0100);
        check_value("hold_set", 32'(hold), 32'd1);
        set_ab(5'b11111, 5'b00000);
        press_key(4'b0001);
        check_value("hold_op", 32'(op), 32'd2);
        check_value("hold_frozen", 32'(result), 32'(5'b11110));
        key = 4'b1011;
        tick(2 + DB);
        check_value("hold_clr", 32'(hold), 32'd0);
        check_value("hold_clr_edge", 32'(result), 32'(5'b11110));
        tick(1);
        check_value("hold_release_res", 32'(result), 32'(5'b11111));
        key = 4'hF;
        tick(10);
        press_key(4'b0100);
        check_value("hold_set2", 32'(hold), 32'd1);
        reset_n = 1'b0;
        tick(1);
        check_value("hold_rst_hold", 32'(hold), 32'd0);
        check_value("hold_rst_res", 32'(result), 32'd0);
        check_value("hold_rst_op", 32'(op), 32'd0);
        reset_n = 1'b1;
        tick(2);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
